// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Frame-level controller for the Flappy Bird VGA demo. Owns the game state
// machine, bird vertical physics, pipe scroll offset, pipe gap position and
// score. All game state advances only on the one-cycle frame tick derived
// from the falling edge of vertical sync, so every output is a register that
// is stable for the whole active-video region.
//
// Ports
//   iVGA_CLK   in   1  pixel clock, the only clock
//   reset      in   1  synchronous, active-high reset
//   iVS        in   1  vertical sync, active low
//   iFLAP      in   1  raw flap button, active high, asynchronous
//   iHIT       in   1  renderer collision flag, valid any cycle
//   oBIRD_Y    out  9  bird top row, 0..SCREEN_H-BIRD_H
//   oSCROLL_X  out 10  pipe scroll offset, 0..SCREEN_W-1
//   oGAP_Y     out  9  top of the current pipe gap
//   oSCORE     out  8  pipes passed, saturating at 255
//   oSTATE     out  2  IDLE=0, PLAY=1, DYING=2, OVER=3
//   oLED_NOTI  out  1  toggles on every score increment
// -----------------------------------------------------------------------------
module game_sequencer #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int BIRD_H       = 16,
   parameter int BIRD_START_Y = 240,
   parameter int FLAP_VEL     = 6,
   parameter int VEL_MAX      = 7,
   parameter int SCROLL_STEP  = 2,
   parameter int GAP_MIN      = 80,
   parameter int DEATH_FRAMES = 60
) (
   input  logic       iVGA_CLK,
   input  logic       reset,
   input  logic       iVS,
   input  logic       iFLAP,
   input  logic       iHIT,
   output logic [8:0] oBIRD_Y,
   output logic [9:0] oSCROLL_X,
   output logic [8:0] oGAP_Y,
   output logic [7:0] oSCORE,
   output logic [1:0] oSTATE,
   output logic       oLED_NOTI
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_DYING = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   localparam logic [8:0]        FLOOR_Y    = 9'(SCREEN_H - BIRD_H);
   localparam logic [8:0]        START_Y    = 9'(BIRD_START_Y);
   localparam logic [8:0]        IDLE_GAP   = 9'(GAP_MIN + 64);
   localparam logic signed [4:0] FLAP_V     = 5'(-FLAP_VEL);
   localparam logic signed [4:0] VMAX       = 5'(VEL_MAX);
   localparam logic [10:0]       SCR_W      = 11'(SCREEN_W);
   localparam logic [10:0]       SCR_STEP   = 11'(SCROLL_STEP);
   localparam logic [7:0]        DEATH_LOAD = 8'(DEATH_FRAMES - 1);

   // ---------------------------------------------------------------------------
   // Input conditioning: frame tick, flap synchronizer, hit latch, LFSR
   // ---------------------------------------------------------------------------
   logic        vs_q, vs_d, tick;
   logic        flap_s1, flap_s2, flap_s3, flap_pend;
   logic        hit_lat;
   logic [15:0] lfsr_q;
   logic        flap_rise;
   logic        lfsr_fb;

   assign flap_rise = flap_s2 & ~flap_s3;
   assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // NOTE: every clocked assignment is non-blocking so all flops sample the
   // pre-edge values; blocking here would let vs_d see the new vs_q.
   always_ff @(posedge iVGA_CLK) begin
      if (reset) begin
         vs_q      <= 1'b0;
         vs_d      <= 1'b0;
         tick      <= 1'b0;
         flap_s1   <= 1'b0;
         flap_s2   <= 1'b0;
         flap_s3   <= 1'b0;
         flap_pend <= 1'b0;
         hit_lat   <= 1'b0;
         lfsr_q    <= 16'hACE1;
      end else begin
         vs_q    <= iVS;
         vs_d    <= vs_q;
         tick    <= vs_d & ~vs_q;
         flap_s1 <= iFLAP;
         flap_s2 <= flap_s1;
         flap_s3 <= flap_s2;
         lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
         // The tick consumes the pending value; an event arriving on the same
         // cycle survives into the next frame.
         if (tick) begin
            flap_pend <= flap_rise;
            hit_lat   <= iHIT;
         end else begin
            flap_pend <= flap_pend | flap_rise;
            hit_lat   <= hit_lat | iHIT;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Game state registers
   // ---------------------------------------------------------------------------
   state_t            state_q, state_n;
   logic [8:0]        bird_q, bird_n;
   logic signed [4:0] vel_q, vel_n;
   logic [9:0]        scroll_q, scroll_n;
   logic [8:0]        gap_q, gap_n;
   logic [7:0]        score_q, score_n;
   logic              led_q, led_n;
   logic [7:0]        dcnt_q, dcnt_n;

   always_ff @(posedge iVGA_CLK) begin
      if (reset) begin
         state_q  <= S_IDLE;
         bird_q   <= START_Y;
         vel_q    <= 5'sd0;
         scroll_q <= 10'd0;
         gap_q    <= IDLE_GAP;
         score_q  <= 8'd0;
         led_q    <= 1'b0;
         dcnt_q   <= 8'd0;
      end else if (tick) begin
         state_q  <= state_n;
         bird_q   <= bird_n;
         vel_q    <= vel_n;
         scroll_q <= scroll_n;
         gap_q    <= gap_n;
         score_q  <= score_n;
         led_q    <= led_n;
         dcnt_q   <= dcnt_n;
      end
   end

   // Physics and scroll arithmetic used by PLAY and DYING.
   logic signed [4:0]  vel_inc, vel_new;
   logic signed [10:0] y_sum;
   logic [10:0]        s_sum;
   logic               s_wrap;
   logic [9:0]         fall_sum;
   logic [8:0]         fall_y;

   always_comb begin
      vel_inc  = (vel_q >= VMAX) ? VMAX : vel_q + 5'sd1;
      vel_new  = flap_pend ? FLAP_V : vel_inc;
      // Velocity first, then position with the new velocity.
      y_sum    = $signed({2'b00, bird_q}) + $signed({{6{vel_new[4]}}, vel_new});
      s_sum    = {1'b0, scroll_q} + SCR_STEP;
      s_wrap   = (s_sum >= SCR_W);
      fall_sum = {1'b0, bird_q} + 10'(VEL_MAX);
      fall_y   = (fall_sum >= {1'b0, FLOOR_Y}) ? FLOOR_Y : fall_sum[8:0];
   end

   // NOTE: every next-state signal gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n  = state_q;
      bird_n   = bird_q;
      vel_n    = vel_q;
      scroll_n = scroll_q;
      gap_n    = gap_q;
      score_n  = score_q;
      led_n    = led_q;
      dcnt_n   = dcnt_q;

      case (state_q)
         S_IDLE: begin
            bird_n   = START_Y;
            vel_n    = 5'sd0;
            scroll_n = 10'd0;
            score_n  = 8'd0;
            gap_n    = IDLE_GAP;
            if (flap_pend) begin
               state_n = S_PLAY;
               vel_n   = FLAP_V;
            end
         end

         S_PLAY: begin
            if (hit_lat) begin
               // Collision freezes everything on the death frame.
               state_n = S_DYING;
               dcnt_n  = DEATH_LOAD;
            end else begin
               vel_n = vel_new;
               if (y_sum < 11'sd0) begin
                  bird_n = 9'd0;
               end else if (y_sum >= $signed({2'b00, FLOOR_Y})) begin
                  bird_n  = FLOOR_Y;
                  state_n = S_DYING;
                  dcnt_n  = DEATH_LOAD;
               end else begin
                  bird_n = y_sum[8:0];
               end

               if (s_wrap) begin
                  scroll_n = 10'(s_sum - SCR_W);
                  score_n  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                  led_n    = ~led_q;
                  gap_n    = 9'(GAP_MIN) + {1'b0, lfsr_q[7:0]};
               end else begin
                  scroll_n = s_sum[9:0];
               end
            end
         end

         S_DYING: begin
            bird_n = fall_y;
            if (dcnt_q == 8'd0) begin
               state_n = S_OVER;
            end else begin
               dcnt_n = dcnt_q - 8'd1;
            end
         end

         S_OVER: begin
            if (flap_pend) begin
               state_n  = S_IDLE;
               bird_n   = START_Y;
               vel_n    = 5'sd0;
               scroll_n = 10'd0;
               score_n  = 8'd0;
               gap_n    = IDLE_GAP;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   assign oBIRD_Y   = bird_q;
   assign oSCROLL_X = scroll_q;
   assign oGAP_Y    = gap_q;
   assign oSCORE    = score_q;
   assign oSTATE    = state_q;
   assign oLED_NOTI = led_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed bench for game_sequencer. Frames are generated by hand: each tick
// drops iVS for two cycles and the registered outputs are read three falling
// clock edges after iVS falls. Expected values are hand-derived constants or
// come from a small physics/scroll/score model kept in the bench.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       vs    = 1'b1;
   logic       flap  = 1'b0;
   logic       hit   = 1'b0;
   logic [8:0] bird_y;
   logic [9:0] scroll_x;
   logic [8:0] gap_y;
   logic [7:0] score;
   logic [1:0] state;
   logic       led;

   int vectors     = 0;
   int miscompares = 0;

   // Play-phase model
   int exp_scroll;
   int exp_score;
   int exp_led;
   int flap_phase;
   int m_y;
   int m_vel;
   bit died;

   game_sequencer dut (
      .iVGA_CLK  (clk),
      .reset     (reset),
      .iVS       (vs),
      .iFLAP     (flap),
      .iHIT      (hit),
      .oBIRD_Y   (bird_y),
      .oSCROLL_X (scroll_x),
      .oGAP_Y    (gap_y),
      .oSCORE    (score),
      .oSTATE    (state),
      .oLED_NOTI (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_flap();
      flap = 1'b1;
      repeat (2) @(negedge clk);
      flap = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic hit_pulse();
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // Frame tick; optionally hold iHIT high on exactly the cycle tick is high.
   task automatic vs_tick(input bit hit_on_tick);
      vs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vs  = 1'b1;
      hit = hit_on_tick;
      @(negedge clk);
      hit = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_idle_values(input string tag, input int exp_led_v);
      check({tag, "_state"},  32'(state),    0);
      check({tag, "_bird"},   32'(bird_y),   240);
      check({tag, "_scroll"}, 32'(scroll_x), 0);
      check({tag, "_score"},  32'(score),    0);
      check({tag, "_gap"},    32'(gap_y),    144);
      check({tag, "_led"},    32'(led),      32'(exp_led_v));
   endtask

   // PLAY ticks with a flap before every sixth one to stay airborne.
   task automatic play_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         if (flap_phase == 5) begin
            press_flap();
            flap_phase = 0;
         end else begin
            idle(6);
            flap_phase++;
         end
         vs_tick(1'b0);
         exp_scroll += 2;
         if (exp_scroll >= 640) begin
            exp_scroll -= 640;
            if (exp_score < 255) exp_score++;
            exp_led ^= 1;
            check("wrap_gap_range", 32'(gap_y >= 9'd80 && gap_y <= 9'd335), 1);
         end
         check("play_state",  32'(state),    1);
         check("play_scroll", 32'(scroll_x), 32'(exp_scroll));
         check("play_score",  32'(score),    32'(exp_score));
         check("play_led",    32'(led),      32'(exp_led));
      end
   endtask

   // DYING countdown: OVER is reached on the 60th tick after entry.
   task automatic dying_ticks(input int exp_bird, input int hold_scroll, input int hold_score);
      for (int i = 1; i <= 60; i++) begin
         idle(6);
         vs_tick(1'b0);
         check("dying_state",  32'(state),    (i < 60) ? 2 : 3);
         check("dying_bird",   32'(bird_y),   32'(exp_bird));
         check("dying_scroll", 32'(scroll_x), 32'(hold_scroll));
         check("dying_score",  32'(score),    32'(hold_score));
      end
   endtask

   initial begin
      // ---------------- Reset and hold ----------------
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      check_idle_values("reset", 0);
      for (int f = 0; f < 3; f++) begin
         idle(6);
         vs_tick(1'b0);
         check("hold_state",  32'(state),    0);
         check("hold_bird",   32'(bird_y),   240);
         check("hold_scroll", 32'(scroll_x), 0);
         check("hold_score",  32'(score),    0);
      end

      // ---------------- Start and first frames ----------------
      press_flap();
      vs_tick(1'b0);
      check("start_state",  32'(state),    1);
      check("start_bird",   32'(bird_y),   240);
      check("start_scroll", 32'(scroll_x), 0);
      press_flap();                       // flap: vel -6
      vs_tick(1'b0);
      check("tick2_bird",   32'(bird_y),   234);
      check("tick2_scroll", 32'(scroll_x), 2);
      idle(6);                            // no flap: vel -5
      vs_tick(1'b0);
      check("tick3_bird",   32'(bird_y),   229);

      // ---------------- Floor death ----------------
      m_y   = 229;
      m_vel = -5;
      died  = 1'b0;
      for (int i = 0; i < 100 && !died; i++) begin
         idle(6);
         vs_tick(1'b0);
         m_vel = (m_vel >= 7) ? 7 : m_vel + 1;
         m_y   = m_y + m_vel;
         if (m_y >= 464) begin
            m_y  = 464;
            died = 1'b1;
         end
         check("fall_bird",  32'(bird_y), 32'(m_y));
         check("fall_state", 32'(state),  died ? 2 : 1);
      end
      check("fall_reached_floor", 32'(died), 1);
      exp_scroll = int'(scroll_x);
      dying_ticks(464, exp_scroll, 0);
      idle(6);
      vs_tick(1'b0);
      check("over_hold_state", 32'(state),  3);
      check("over_hold_bird",  32'(bird_y), 464);
      press_flap();
      vs_tick(1'b0);
      check_idle_values("restart", 0);

      // ---------------- Scroll wrap and score ----------------
      press_flap();
      vs_tick(1'b0);
      check("wrap_start_state", 32'(state), 1);
      exp_scroll = 0;
      exp_score  = 0;
      exp_led    = 0;
      flap_phase = 0;
      play_ticks(319);
      check("pre_wrap_scroll", 32'(scroll_x), 638);
      check("pre_wrap_score",  32'(score),    0);
      play_ticks(1);
      check("wrap1_scroll", 32'(scroll_x), 0);
      check("wrap1_score",  32'(score),    1);
      check("wrap1_led",    32'(led),      1);

      force dut.score_q = 8'd254;
      @(negedge clk);
      release dut.score_q;
      @(negedge clk);
      exp_score = 254;
      check("forced_score", 32'(score), 254);
      play_ticks(320);
      check("wrap2_score", 32'(score), 255);
      check("wrap2_led",   32'(led),   0);
      play_ticks(320);
      check("wrap3_score_sat", 32'(score), 255);
      check("wrap3_led",       32'(led),   1);

      // Stop flapping: fall to the floor with score frozen at 255.
      for (int i = 0; i < 200 && state == 2'd1; i++) begin
         idle(6);
         vs_tick(1'b0);
         exp_scroll += 2;
      end
      check("sat_death_state",  32'(state),    2);
      check("sat_death_bird",   32'(bird_y),   464);
      check("sat_death_scroll", 32'(scroll_x), 32'(exp_scroll));
      dying_ticks(464, exp_scroll, 255);
      press_flap();
      vs_tick(1'b0);
      check_idle_values("sat_restart", 1);

      // ---------------- Hit mid-frame ----------------
      do_reset(2);
      @(negedge clk);
      press_flap();
      vs_tick(1'b0);                      // PLAY, bird 240
      press_flap();
      vs_tick(1'b0);                      // bird 234, scroll 2
      idle(6);
      vs_tick(1'b0);                      // bird 229, scroll 4
      check("pre_hit_bird", 32'(bird_y), 229);
      hit_pulse();
      vs_tick(1'b0);
      check("hit_state",  32'(state),    2);
      check("hit_bird",   32'(bird_y),   229);
      check("hit_scroll", 32'(scroll_x), 4);
      idle(6);
      vs_tick(1'b0);
      check("hit_fall_bird",  32'(bird_y), 236);
      check("hit_fall_state", 32'(state),  2);

      // ---------------- Hit coincident with tick ----------------
      do_reset(2);
      @(negedge clk);
      press_flap();
      vs_tick(1'b0);                      // PLAY, bird 240, vel -6
      idle(6);
      vs_tick(1'b1);                      // hit lands on the tick
      check("coinc_state",  32'(state),    1);
      check("coinc_bird",   32'(bird_y),   235);
      check("coinc_scroll", 32'(scroll_x), 2);
      idle(6);
      vs_tick(1'b0);
      check("coinc_next_state",  32'(state),    2);
      check("coinc_next_bird",   32'(bird_y),   235);
      check("coinc_next_scroll", 32'(scroll_x), 2);

      // ---------------- Mid-game reset ----------------
      force dut.score_q = 8'd5;
      @(negedge clk);
      release dut.score_q;
      @(negedge clk);
      check("mid_pre_score", 32'(score), 5);
      check("mid_pre_state", 32'(state), 2);
      do_reset(1);
      check_idle_values("mid_reset", 0);
      press_flap();
      vs_tick(1'b0);
      check("mid_restart_state", 32'(state),  1);
      check("mid_restart_bird",  32'(bird_y), 240);
      idle(6);
      vs_tick(1'b0);
      check("mid_restart_bird2",  32'(bird_y),   235);
      check("mid_restart_scroll", 32'(scroll_x), 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-level game controller for the Flappy Bird VGA demo. It owns the game state machine, bird vertical physics, pipe scroll offset, pipe gap position and score. It advances exactly once per video frame, keyed off the vertical sync from `video_sync_generator`. Its registered outputs feed the pixel renderer and the bird/background address generators, and are stable for the whole active-video region.

## Interface

Parameters:
- `SCREEN_W`, 640: horizontal wrap limit for the scroll offset.
- `SCREEN_H`, 480: vertical extent of the playfield.
- `BIRD_H`, 16: bird sprite height; floor is at `SCREEN_H-BIRD_H`.
- `BIRD_START_Y`, 240: bird Y in IDLE.
- `FLAP_VEL`, 6: upward speed applied on a flap, in px/frame.
- `VEL_MAX`, 7: terminal fall speed, in px/frame.
- `SCROLL_STEP`, 2: scroll advance per frame in PLAY.
- `GAP_MIN`, 80: minimum pipe gap Y.
- `DEATH_FRAMES`, 60: length of the DYING animation, in frames.

Ports:
- `iVGA_CLK`, in, 1: pixel clock; the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `iVS`, in, 1: vertical sync, active low, from `video_sync_generator`.
- `iFLAP`, in, 1: raw flap button, active high, asynchronous.
- `iHIT`, in, 1: renderer collision flag (bird pixel over pipe pixel), valid any cycle.
- `oBIRD_Y`, out, 9: bird top row, range 0..`SCREEN_H-BIRD_H`.
- `oSCROLL_X`, out, 10: pipe scroll offset, range 0..`SCREEN_W-1`.
- `oGAP_Y`, out, 9: top of the current pipe gap.
- `oSCORE`, out, 8: pipes passed; saturates at 255.
- `oSTATE`, out, 2: game state, encoded IDLE=0, PLAY=1, DYING=2, OVER=3.
- `oLED_NOTI`, out, 1: toggles on every score increment.

## Operation

Per-cycle input handling:
- **Frame tick:** `iVS` is registered once, then a 1→0 edge on the registered copy produces `tick`, a one-cycle pulse.
- **Flap:** `iFLAP` passes through a 2-flop synchronizer, then rising-edge detection. A detected edge sets `flap_pend`, which is cleared on the tick that consumes it. A press between ticks is never lost. Multiple presses between ticks count as one.
- **Hit:** `hit_lat` is set on any cycle with `iHIT=1` and cleared on `tick`. If `iHIT` and `tick` occur in the same cycle, `tick` consumes the old value and `hit_lat` is then set, so the hit is counted on the next frame.
- **LFSR:** a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 steps every clock.

Per-tick state machine. Nothing changes between ticks.
- **IDLE:**
  - Bird Y is `BIRD_START_Y`, vel=0, scroll=0, score=0, gap=`GAP_MIN`+64.
  - If `flap_pend`: go to PLAY and set vel=-`FLAP_VEL`. Bird Y stays unchanged on this tick.
- **PLAY:** evaluated in this priority order.
  1. If `hit_lat`: go to DYING. Nothing else moves on this tick.
  2. Otherwise compute vel' = `flap_pend` ? -`FLAP_VEL` : min(vel+1, `VEL_MAX`). Velocity is a 5-bit signed value.
  3. Compute y' = bird_y + vel' in 11-bit signed. If y'<0, clamp to 0 (ceiling; not fatal). If y' ≥ `SCREEN_H-BIRD_H`, clamp to the floor and go to DYING.
  4. Compute s = scroll + `SCROLL_STEP`. If s ≥ `SCREEN_W`:
     - scroll = s - `SCREEN_W`;
     - score = min(score+1, 255);
     - toggle `oLED_NOTI`;
     - gap = `GAP_MIN` + lfsr[7:0], giving a range of 80..335.
  5. Otherwise scroll = s.
- **DYING:**
  - A frame counter loads `DEATH_FRAMES-1` on entry.
  - Each tick: bird falls `VEL_MAX` px, clamped at the floor. Scroll, gap and score are frozen.
  - At count 0 the next tick goes to OVER.
  - Flaps are consumed and ignored.
- **OVER:**
  - All outputs hold.
  - If `flap_pend` at a tick: go to IDLE. All IDLE values load on that tick, except `oLED_NOTI`, which holds.

Reset, including mid-frame or mid-game:
- state=IDLE, `oBIRD_Y`=`BIRD_START_Y`, `oSCROLL_X`=0, `oGAP_Y`=`GAP_MIN`+64, `oSCORE`=0, `oLED_NOTI`=0.
- vel=0, `flap_pend`=0, `hit_lat`=0, LFSR=seed, synchronizers=0.

## Timing

- `tick` asserts 2 cycles after `iVS` falls at the pins.
- All outputs are registered and update on the cycle after `tick`, i.e. 3 cycles after `iVS` falls, well inside vertical sync. They are constant through active video.
- Flap latency: a press is registered by `flap_pend` 3 cycles after the `iFLAP` rise. It takes effect at the first tick after that.
- Physics ordering within a tick: velocity is updated first; the position then uses the new velocity.
- One state transition per tick maximum.

## Test plan

- **Reset and hold:** reset, then 3 frames with no flap → state stays 0; bird=240, scroll=0, score=0 on every frame.
- **Start and first frames:** flap pulse in frame 0 → state=1 after tick 1 with bird=240. After tick 2: vel=-6, bird=234. After tick 3: vel=-5, bird=229.
- **Scroll wrap and score:** in PLAY, flap every 6 frames to stay airborne → scroll reaches 638, then 0 on the next tick. On that tick score goes 0→1, `oLED_NOTI` toggles and `oGAP_Y` is in 80..335. Force score=255, then wrap again → score stays at 255.
- **Floor death:** no flaps from bird=240 → bird reaches floor 464 and state=2 on the same tick. After 60 further ticks state=3. A flap then returns to state=0 with score=0.
- **Hit handling:** pulse `iHIT` for 1 cycle mid-frame → state=2 at the next tick and bird Y unchanged on that tick. Pulse `iHIT` coincident with `tick` → death is taken on the following tick.
- **Mid-game reset:** assert `reset` for 1 cycle while in DYING with score=5 → the next cycle shows all outputs at their reset values, and a flap restarts normally.
